// File: rtl/iic_cfg_sequencer_pkg.sv
// Shared constants and types for the DVI transmitter I2C config sequencer.
// Holds the FSM encoding, the register table entries and the target address.
package iic_cfg_sequencer_pkg;

  localparam logic [6:0] DVI_SLAVE_ADDR = 7'h76;
  localparam int         DVI_NUM_WRITES = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4,
    S_FAIL = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [7:0] ra;
    logic [7:0] hi;
    logic [7:0] lo;
  } dvi_cfg_t;

  // hi = pixel clock above 65 MHz, lo = at or below
  localparam dvi_cfg_t DVI_CFG_0 = '{ra: 8'h49, hi: 8'hC0, lo: 8'hC0};
  localparam dvi_cfg_t DVI_CFG_1 = '{ra: 8'h21, hi: 8'h09, lo: 8'h09};
  localparam dvi_cfg_t DVI_CFG_2 = '{ra: 8'h33, hi: 8'h06, lo: 8'h08};
  localparam dvi_cfg_t DVI_CFG_3 = '{ra: 8'h34, hi: 8'h26, lo: 8'h16};
  localparam dvi_cfg_t DVI_CFG_4 = '{ra: 8'h36, hi: 8'hA0, lo: 8'h60};

endpackage

// File: rtl/iic_cfg_rom.sv
// Combinational lookup of the DVI register table.
// Maps (entry index, clock band) to a register address and data byte.
module iic_cfg_rom
  import iic_cfg_sequencer_pkg::*;
#(
  parameter int IW = 3
) (
  input  logic [IW-1:0] idx,
  input  logic          band,
  output logic [7:0]    reg_addr,
  output logic [7:0]    reg_data
);

  dvi_cfg_t e;

  always_comb begin
    e = '0;
    case (int'(idx))
      0:       e = DVI_CFG_0;
      1:       e = DVI_CFG_1;
      2:       e = DVI_CFG_2;
      3:       e = DVI_CFG_3;
      4:       e = DVI_CFG_4;
      default: e = '0;
    endcase
    reg_addr = e.ra;
    reg_data = band ? e.hi : e.lo;
  end

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Walks the DVI register table over a req/ack I2C byte-write engine.
// Retries on NACK, spaces writes apart and reruns on a clock-band change.
module iic_cfg_sequencer
  import iic_cfg_sequencer_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DVI_SLAVE_ADDR,
  parameter int         NUM_WRITES = DVI_NUM_WRITES,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 3000,
  parameter int         GAP_MSB    = 11
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Pixel_clk_greater_than_65Mhz,
  output logic       Wr_req,
  output logic [6:0] Wr_addr,
  output logic [7:0] Wr_reg,
  output logic [7:0] Wr_data,
  input  logic       Wr_ack,
  input  logic       Wr_nack,
  output logic       Done,
  output logic       Error,
  output logic       Busy
);

  localparam int IW = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef logic [IW-1:0]    idx_t;
  typedef logic [RW-1:0]    rty_t;
  typedef logic [GAP_MSB:0] gap_t;

  localparam idx_t I_LAST = idx_t'(NUM_WRITES - 1);
  localparam rty_t R_MAX  = rty_t'(MAX_RETRY);
  localparam gap_t G_LAST = gap_t'(GAP_CYCLES - 1);

  seq_state_t state;
  idx_t       idx;
  rty_t       retry;
  gap_t       gap;
  logic       band;
  logic       boot;
  logic [7:0] rom_reg;
  logic [7:0] rom_data;
  logic       band_chg;
  logic       restart;

  iic_cfg_rom #(.IW(IW)) u_rom (
    .idx      (idx),
    .band     (band),
    .reg_addr (rom_reg),
    .reg_data (rom_data)
  );

  assign Wr_addr  = SLAVE_ADDR;
  assign Busy     = (state != S_IDLE) && (state != S_DONE) && (state != S_FAIL);
  assign band_chg = Pixel_clk_greater_than_65Mhz ^ band;

  // boot makes the first cycle out of reset act as a Start pulse
  assign restart = ((state == S_IDLE) && (Start || boot))
                || ((state == S_DONE) && (Start || band_chg))
                || ((state == S_FAIL) && Start);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      retry   <= '0;
      gap     <= '0;
      band    <= 1'b0;
      boot    <= 1'b1;
      Wr_req  <= 1'b0;
      Wr_reg  <= '0;
      Wr_data <= '0;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else begin
      boot <= 1'b0;
      if (restart) begin
        band  <= Pixel_clk_greater_than_65Mhz;
        idx   <= '0;
        retry <= '0;
        Done  <= 1'b0;
        Error <= 1'b0;
        state <= S_LOAD;
      end else begin
        unique case (state)
          S_LOAD: begin
            Wr_reg  <= rom_reg;
            Wr_data <= rom_data;
            Wr_req  <= 1'b1;
            state   <= S_WAIT;
          end
          S_WAIT: begin
            if (Wr_ack) begin
              Wr_req <= 1'b0;
              gap    <= '0;
              if (!Wr_nack) begin
                if (idx == I_LAST) begin
                  Done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  idx   <= idx + 1'b1;
                  retry <= '0;
                  state <= S_GAP;
                end
              end else if (retry != R_MAX) begin
                retry <= retry + 1'b1;
                state <= S_GAP;
              end else begin
                Error <= 1'b1;
                state <= S_FAIL;
              end
            end
          end
          S_GAP: begin
            if (gap == G_LAST) begin
              gap   <= '0;
              state <= S_LOAD;
            end else begin
              gap <= gap + 1'b1;
            end
          end
          S_IDLE, S_DONE, S_FAIL: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// Directed bench for iic_cfg_sequencer with a fixed-latency I2C engine model.
// Engine acks 50 cycles after each request and can NACK a chosen register.
module tb_iic_cfg_sequencer;

  localparam int GAP     = 20;
  localparam int ACK_DLY = 50;
  localparam int SPACE   = ACK_DLY + GAP + 1;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Start = 1'b0;
  logic       band = 1'b1;
  logic       Wr_ack = 1'b0;
  logic       Wr_nack = 1'b0;
  logic       Wr_req;
  logic [6:0] Wr_addr;
  logic [7:0] Wr_reg;
  logic [7:0] Wr_data;
  logic       Done;
  logic       Error;
  logic       Busy;

  iic_cfg_sequencer #(
    .GAP_CYCLES (GAP),
    .GAP_MSB    (7)
  ) dut (
    .Clk                          (Clk),
    .Reset_n                      (Reset_n),
    .Start                        (Start),
    .Pixel_clk_greater_than_65Mhz (band),
    .Wr_req                       (Wr_req),
    .Wr_addr                      (Wr_addr),
    .Wr_reg                       (Wr_reg),
    .Wr_data                      (Wr_data),
    .Wr_ack                       (Wr_ack),
    .Wr_nack                      (Wr_nack),
    .Done                         (Done),
    .Error                        (Error),
    .Busy                         (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t        wlog[$];
  int         cyc = 0;
  int         base = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         stab_err = 0;
  int         hs_err = 0;
  int         cnt = 0;
  int         nack_max = 0;
  logic [7:0] nack_reg = 8'h00;
  logic       prev_req = 1'b0;
  logic [7:0] prev_reg = 8'h00;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] exp_reg [5] = '{8'h49, 8'h21, 8'h33, 8'h34, 8'h36};
  logic [7:0] exp_hi  [5] = '{8'hC0, 8'h09, 8'h06, 8'h26, 8'hA0};
  logic [7:0] exp_lo  [5] = '{8'hC0, 8'h09, 8'h08, 8'h16, 8'h60};

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int count_reg(input logic [7:0] r);
    int n = 0;
    for (int i = base; i < wlog.size(); i++)
      if (wlog[i].r == r) n++;
    return n;
  endfunction

  always @(negedge Clk) begin
    if (!Reset_n) begin
      cnt      = 0;
      Wr_ack   = 1'b0;
      Wr_nack  = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (Wr_req && !prev_req) wlog.push_back('{Wr_reg, Wr_data, cyc});
      if (Wr_req && prev_req && (Wr_reg != prev_reg || Wr_data != prev_data))
        stab_err++;
      if (!Wr_req && prev_req && !Wr_ack) hs_err++;
      Wr_ack  = 1'b0;
      Wr_nack = 1'b0;
      if (Wr_req) begin
        cnt++;
        if (cnt == ACK_DLY) begin
          cnt    = 0;
          Wr_ack = 1'b1;
          if (Wr_reg == nack_reg && count_reg(nack_reg) <= nack_max)
            Wr_nack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
      prev_req  = Wr_req;
      prev_reg  = Wr_reg;
      prev_data = Wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    tick(3);
    while (Busy && t < 3000) begin
      tick(1);
      t++;
    end
    chk({tag, "_timeout"}, Busy, 0);
  endtask

  task automatic chk_spacing(input string tag);
    int bad = 0;
    for (int i = base + 1; i < wlog.size(); i++)
      if (wlog[i].c - wlog[i-1].c != SPACE) bad++;
    chk({tag, "_spacing"}, bad, 0);
  endtask

  task automatic check_run(input string tag, input logic b);
    chk({tag, "_nwr"}, wlog.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < wlog.size()) begin
        chk($sformatf("%s_reg%0d", tag, i), wlog[base+i].r, exp_reg[i]);
        chk($sformatf("%s_dat%0d", tag, i), wlog[base+i].d,
            b ? exp_hi[i] : exp_lo[i]);
      end
    end
    chk_spacing(tag);
    chk({tag, "_done"}, Done, 1);
    chk({tag, "_error"}, Error, 0);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_handshake"}, hs_err, 0);
  endtask

  initial begin
    int bad;
    int t;
    #1 Reset_n = 1'b0;
    tick(2);
    chk("rst_req", Wr_req, 0);
    chk("rst_reg", Wr_reg, 0);
    chk("rst_data", Wr_data, 0);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_busy", Busy, 0);
    chk("addr", Wr_addr, 7'h76);
    base = wlog.size();
    Reset_n = 1'b1;
    tick(1);
    chk("lat1_req", Wr_req, 0);
    chk("lat1_busy", Busy, 1);
    tick(1);
    chk("lat2_req", Wr_req, 1);
    chk("lat2_reg", Wr_reg, 8'h49);
    wait_idle("run_hi");
    check_run("run_hi", 1'b1);

    base = wlog.size();
    band = 1'b0;
    wait_idle("band_lo");
    check_run("band_lo", 1'b0);

    base = wlog.size();
    band  = 1'b1;
    pulse_start();
    wait_idle("start_band");
    tick(100);
    check_run("start_band", 1'b1);

    base = wlog.size();
    nack_reg = 8'h34;
    nack_max = 2;
    pulse_start();
    wait_idle("nack3");
    chk("nack3_nwr", wlog.size() - base, 7);
    chk("nack3_tries", count_reg(8'h34), 3);
    bad = 0;
    for (int i = base; i < wlog.size(); i++)
      if (wlog[i].r == 8'h34 && wlog[i].d != 8'h26) bad++;
    chk("nack3_data", bad, 0);
    chk_spacing("nack3");
    chk("nack3_done", Done, 1);
    chk("nack3_error", Error, 0);

    base = wlog.size();
    nack_reg = 8'h21;
    nack_max = 99;
    pulse_start();
    wait_idle("fail1");
    chk("fail1_tries", count_reg(8'h21), 4);
    chk("fail1_nwr", wlog.size() - base, 5);
    chk("fail1_error", Error, 1);
    chk("fail1_done", Done, 0);
    band = 1'b0;
    tick(100);
    chk("fail_band_nwr", wlog.size() - base, 5);
    chk("fail_band_busy", Busy, 0);
    chk("fail_band_error", Error, 1);

    nack_max = 0;
    base = wlog.size();
    pulse_start();
    wait_idle("from_fail");
    check_run("from_fail", 1'b0);

    base = wlog.size();
    pulse_start();
    t = 0;
    while (wlog.size() - base < 3 && t < 3000) begin
      tick(1);
      t++;
    end
    tick(1);
    chk("mid_reach", wlog.size() - base, 3);
    chk("mid_req_hi", Wr_req, 1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_req", Wr_req, 0);
    chk("mid_rst_busy", Busy, 0);
    tick(2);
    base = wlog.size();
    Reset_n = 1'b1;
    wait_idle("after_rst");
    check_run("after_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
